// File: rtl/lfsr_pkg.sv
// lfsr_pkg: maximal-length tap constants and request FSM encoding shared by the LFSR blocks
package lfsr_pkg;
    localparam logic [7:0]  LFSR8_TAPS  = 8'h1D;
    localparam logic [9:0]  LFSR10_TAPS = 10'h081;
    localparam logic [15:0] LFSR16_TAPS = 16'h6801;
    typedef enum logic {IDLE, SAMPLE} fsm_e;
endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: Galois LFSR state register with seed load, zero-state recovery and lockup pulse
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 10,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR10_TAPS),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(10'h0FF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] state_o,
    output logic             lockup_o
);
    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_core: SEED must be nonzero");
    end
    if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
        $error("lfsr_core: WIDTH must be 3..32");
    end
    localparam logic [WIDTH-1:0] TAPS_EFF = TAPS | WIDTH'(1);
    logic [WIDTH-1:0] state_q, state_d, stepped;
    logic             lockup_q, lockup_d;
    assign stepped = {state_q[WIDTH-2:0], 1'b0} ^ (TAPS_EFF & {WIDTH{state_q[WIDTH-1]}});
    always_comb begin
        state_d  = load_i ? ((load_val_i == '0) ? SEED : load_val_i)
                 : (state_q == '0) ? SEED
                 : step_i ? stepped : state_q;
        lockup_d = load_i ? (load_val_i == '0) : (state_q == '0);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SEED;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lockup_q <= lockup_d;
        end
    end
    assign state_o  = state_q;
    assign lockup_o = lockup_q;
endmodule

// File: rtl/lfsr_rand_gen.sv
// lfsr_rand_gen: LFSR random source with a rejection-sampled bounded-value request port
module lfsr_rand_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH     = 10,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(LFSR10_TAPS),
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(10'h0FF),
    parameter int unsigned      OUT_W     = 8,
    parameter int unsigned      MAX_TRIES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] lfsr_out,
    output logic             lockup,
    input  logic             req,
    input  logic [OUT_W-1:0] limit,
    output logic             busy,
    output logic             rand_valid,
    output logic [OUT_W-1:0] rand_val,
    output logic             fallback
);
    if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_out_w
        $error("lfsr_rand_gen: OUT_W must be 1..WIDTH");
    end
    if (MAX_TRIES < 1) begin : g_bad_tries
        $error("lfsr_rand_gen: MAX_TRIES must be >= 1");
    end
    localparam int TW = $clog2(MAX_TRIES + 1);
    fsm_e             state_q;
    logic [OUT_W:0]   limit_q;
    logic [TW-1:0]    tries_q;
    logic             rand_valid_q, fallback_q;
    logic [OUT_W-1:0] rand_val_q;
    assign busy = (state_q == SAMPLE);
    // The LFSR free-runs while sampling so each try sees a fresh candidate
    lfsr_core #(.WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED)) u_core (
        .clk        (clk),
        .rst        (rst),
        .step_i     (en | busy),
        .load_i     (seed_load),
        .load_val_i (seed_in),
        .state_o    (lfsr_out),
        .lockup_o   (lockup)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            limit_q      <= '0;
            tries_q      <= '0;
            rand_valid_q <= 1'b0;
            rand_val_q   <= '0;
            fallback_q   <= 1'b0;
        end else begin
            rand_valid_q <= 1'b0;
            if (state_q == IDLE) begin
                if (req) begin
                    limit_q <= (limit == '0) ? {1'b1, {OUT_W{1'b0}}} : {1'b0, limit};
                    tries_q <= '0;
                    state_q <= SAMPLE;
                end
            end else if ({1'b0, lfsr_out[OUT_W-1:0]} < limit_q) begin
                rand_val_q   <= lfsr_out[OUT_W-1:0];
                fallback_q   <= 1'b0;
                rand_valid_q <= 1'b1;
                state_q      <= IDLE;
            end else if (tries_q == TW'(MAX_TRIES - 1)) begin
                rand_val_q   <= OUT_W'(limit_q - (OUT_W + 1)'(1));
                fallback_q   <= 1'b1;
                rand_valid_q <= 1'b1;
                state_q      <= IDLE;
            end else begin
                tries_q <= tries_q + TW'(1);
            end
        end
    end
    assign rand_valid = rand_valid_q;
    assign rand_val   = rand_val_q;
    assign fallback   = fallback_q;
endmodule

// File: tb/tb_lfsr_rand_gen.sv
// tb_lfsr_rand_gen: directed vectors plus a per-cycle reference model for lfsr_rand_gen
module tb_lfsr_rand_gen;
    localparam int W = 10, OW = 8, MT = 4, TP = 'h081, SD = 'h0FF;
    logic clk = 0, rst = 1, en = 0, seed_load = 0, req = 0, en8 = 0;
    logic [9:0] seed_in = '0;
    logic [7:0] limit = '0;
    logic [9:0] lfsr_out;
    logic       lockup, busy, rand_valid, fallback;
    logic [7:0] rand_val;
    logic [7:0] lfsr8, val8;
    logic       lockup8, busy8, valid8, fb8;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    lfsr_rand_gen dut (
        .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(seed_in),
        .lfsr_out(lfsr_out), .lockup(lockup), .req(req), .limit(limit), .busy(busy),
        .rand_valid(rand_valid), .rand_val(rand_val), .fallback(fallback)
    );

    lfsr_rand_gen #(.WIDTH(8), .TAPS(8'h1D), .SEED(8'hFF), .OUT_W(8), .MAX_TRIES(4)) dut8 (
        .clk(clk), .rst(rst), .en(en8), .seed_load(1'b0), .seed_in(8'h00),
        .lfsr_out(lfsr8), .lockup(lockup8), .req(1'b0), .limit(8'h00), .busy(busy8),
        .rand_valid(valid8), .rand_val(val8), .fallback(fb8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int galois(int s, int taps, int w);
        int msb = (s >> (w - 1)) & 1;
        int r = (s << 1) & ((1 << w) - 1);
        return msb ? (r ^ (taps | 1)) : r;
    endfunction

    // Reference model: request described as "try up to MT candidates, else limit-1"
    int m_lfsr, m_tries, m_lim, m_val, m8;
    bit m_lock, m_busy, m_valid, m_fb, m_ok = 0;
    always @(posedge clk) begin
        int cand;
        bit was_busy;
        if (rst) begin
            m_lfsr = SD; m8 = 'hFF; m_lock = 0; m_busy = 0; m_valid = 0;
            m_val = 0; m_fb = 0; m_tries = 0; m_lim = 0; m_ok = 1;
        end else begin
            was_busy = m_busy;
            cand = m_lfsr % (1 << OW);
            m_valid = 0;
            if (!was_busy) begin
                if (req) begin
                    m_busy = 1;
                    m_lim = (limit == 0) ? (1 << OW) : int'(limit);
                    m_tries = 0;
                end
            end else if (cand < m_lim) begin
                m_val = cand; m_fb = 0; m_valid = 1; m_busy = 0;
            end else begin
                m_tries++;
                if (m_tries == MT) begin
                    m_val = m_lim - 1; m_fb = 1; m_valid = 1; m_busy = 0;
                end
            end
            m_lock = 0;
            if (seed_load) begin
                m_lock = (seed_in == 0);
                m_lfsr = m_lock ? SD : int'(seed_in);
            end else if (m_lfsr == 0) begin
                m_lfsr = SD; m_lock = 1;
            end else if (en || was_busy) begin
                m_lfsr = galois(m_lfsr, TP, W);
            end
            if (en8) m8 = galois(m8, 'h1D, 8);
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("m_lfsr", lfsr_out, m_lfsr);
            chk("m_lockup", lockup, m_lock);
            chk("m_busy", busy, m_busy);
            chk("m_valid", rand_valid, m_valid);
            chk("m_val", rand_val, m_val);
            chk("m_fallback", fallback, m_fb);
            chk("m_lfsr8", lfsr8, m8);
            chk("m_lockup8", lockup8, 0);
        end
    end

    initial begin
        int k, dup, cnd;
        bit seen [1024];
        repeat (2) tick();
        rst = 0;
        chk("rst_lfsr", lfsr_out, 'h0FF);
        chk("rst_lfsr8", lfsr8, 'hFF);
        chk("rst_busy", busy, 0);
        chk("rst_valid", rand_valid, 0);
        chk("rst_val", rand_val, 0);
        chk("rst_fb", fallback, 0);
        chk("rst_lockup", lockup, 0);
        chk("rst_idle8", {busy8, valid8, fb8, val8}, 0);
        // 8-bit legacy sequence
        en8 = 1;
        tick();
        chk("step1_e3", lfsr8, 'hE3);
        dup = 0;
        k = 1;
        while (lfsr8 != 8'hFF && k < 300) begin
            if (lfsr8 == 0) dup++;
            tick();
            k++;
        end
        en8 = 0;
        chk("period8", k, 255);
        chk("zero8", dup, 0);
        // 10-bit default: full period, every nonzero state once
        foreach (seen[i]) seen[i] = 0;
        seen['h0FF] = 1;
        dup = 0;
        en = 1;
        for (int i = 1; i <= 1023; i++) begin
            tick();
            if (i < 1023) begin
                if (lfsr_out == 0 || seen[lfsr_out]) dup++;
                seen[lfsr_out] = 1;
            end
        end
        en = 0;
        chk("period10", lfsr_out, 'h0FF);
        chk("unique10", dup, 0);
        seed_load = 1; seed_in = 'h155;
        tick();
        seed_load = 0;
        chk("seed155", lfsr_out, 'h155);
        chk("seed155_lock", lockup, 0);
        repeat (3) tick();
        chk("hold", lfsr_out, 'h155);
        seed_load = 1; seed_in = 0;
        tick();
        seed_load = 0;
        chk("zseed_lfsr", lfsr_out, 'h0FF);
        chk("zseed_lock", lockup, 1);
        tick();
        chk("zseed_lock_end", lockup, 0);
        // Minimum latency, limit=0 means full range
        seed_load = 1; seed_in = 'h155;
        tick();
        seed_load = 0;
        limit = 0; req = 1;
        tick();
        req = 0;
        chk("t4_busy", busy, 1);
        chk("t4_valid_early", rand_valid, 0);
        cnd = int'(lfsr_out[7:0]);
        chk("t4_cand", cnd, 'h55);
        tick();
        chk("t4_valid", rand_valid, 1);
        chk("t4_val", rand_val, 'h55);
        chk("t4_fb", fallback, 0);
        chk("t4_busy_end", busy, 0);
        req = 1;
        tick();
        req = 0;
        chk("b2b_busy", busy, 1);
        tick();
        chk("b2b_valid", rand_valid, 1);
        chk("b2b_val", rand_val, 'hAA);
        // Candidates FF, FE, FC, 79 all >= 3 -> fallback to limit-1
        seed_load = 1; seed_in = 'h0FF;
        tick();
        seed_load = 0;
        limit = 3; req = 1;
        tick();
        req = 1; limit = 0;
        for (int i = 2; i <= 4; i++) begin
            tick();
            req = 0;
            chk("t5_wait", rand_valid, 0);
            chk("t5_busy", busy, 1);
        end
        tick();
        chk("t5_valid", rand_valid, 1);
        chk("t5_val", rand_val, 2);
        chk("t5_fb", fallback, 1);
        tick();
        chk("t5_no_queue_busy", busy, 0);
        chk("t5_no_queue_valid", rand_valid, 0);
        // Reset mid-request
        seed_load = 1; seed_in = 'h0FF;
        tick();
        seed_load = 0;
        limit = 3; req = 1;
        tick();
        req = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        chk("t6_busy", busy, 0);
        chk("t6_lfsr", lfsr_out, 'h0FF);
        chk("t6_valid", rand_valid, 0);
        k = 0;
        repeat (8) begin
            tick();
            if (rand_valid) k++;
        end
        chk("t6_no_valid", k, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
